// File: rtl/console_pkg.sv
// Shared definitions for the console write responder: B response codes,
// responder FSM states and the four legal single-lane write strobes.
package console_pkg;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // One 32-bit lane active, low byte of that lane carries the character.
  localparam logic [15:0] STRB_LANE0 = 16'h000f;
  localparam logic [15:0] STRB_LANE1 = 16'h00f0;
  localparam logic [15:0] STRB_LANE2 = 16'h0f00;
  localparam logic [15:0] STRB_LANE3 = 16'hf000;

  function automatic logic strb_legal(input logic [15:0] strb);
    return (strb == STRB_LANE0) || (strb == STRB_LANE1) ||
           (strb == STRB_LANE2) || (strb == STRB_LANE3);
  endfunction

  function automatic logic [7:0] lane_char(input logic [127:0] data,
                                           input logic [15:0]  strb);
    logic [7:0] ch;
    ch = data[7:0];
    case (strb)
      STRB_LANE1: ch = data[39:32];
      STRB_LANE2: ch = data[71:64];
      STRB_LANE3: ch = data[103:96];
      default:    ch = data[7:0];
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/console_sync_fifo.sv
// Synchronous FIFO holding console characters. DEPTH must be a power of two
// so the read/write pointers wrap naturally.
module console_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic                   push_i,
  input  logic [DATA_W-1:0]      data_i,
  input  logic                   pop_i,
  output logic [DATA_W-1:0]      data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign count_o = count_q;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage write.
  // NOTE: the array is deliberately not reset; entries are only read when the
  // count says they were written, and a reset here would turn RAM into flops.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/axi_console_wr_slave.sv
// AXI4 write responder for the console register. Accepts single-beat writes to
// BASE_ADDR, pushes the active-lane character into a FIFO and answers every
// write on B. Optional feature macro: CONSOLE_UART_TX_EN adds an 8N1 serializer
// that drains the FIFO; otherwise the FIFO drains on char_valid/char_ready.
module axi_console_wr_slave
  import console_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1001_5000,
  parameter int          ID_W       = 8,
  parameter int          FIFO_DEPTH = 16,
  parameter int          CLK_DIV    = 16
) (
  input  logic                        clk,
  input  logic                        rst_b,
  input  logic                        awvalid_i,
  output logic                        awready_o,
  input  logic [39:0]                 awaddr_i,
  input  logic [3:0]                  awlen_i,
  input  logic [ID_W-1:0]             awid_i,
  input  logic                        wvalid_i,
  output logic                        wready_o,
  input  logic [127:0]                wdata_i,
  input  logic [15:0]                 wstrb_i,
  input  logic                        wlast_i,
  output logic                        bvalid_o,
  input  logic                        bready_i,
  output logic [ID_W-1:0]             bid_o,
  output logic [1:0]                  bresp_o,
  output logic                        char_valid_o,
  input  logic                        char_ready_i,
  output logic [7:0]                  char_data_o,
  output logic                        uart_sout_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt_o
);

  state_e          state_q, state_d;
  logic            ok_q, ok_d;
  logic [ID_W-1:0] id_q, id_d;
  logic            push, pop, full, empty;
  logic [7:0]      fifo_data;

  console_sync_fifo #(.DATA_W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_b   (rst_b),
    .push_i  (push),
    .data_i  (lane_char(wdata_i, wstrb_i)),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fifo_cnt_o)
  );

  assign char_valid_o = !empty;
  assign char_data_o  = fifo_data;

  // Responder state, transaction status and latched ID.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= ST_IDLE;
      ok_q    <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ok_q    <= ok_d;
      id_q    <= id_d;
    end
  end

  // Next-state, handshake outputs and FIFO push decode.
  // NOTE: every output and next-state is defaulted first so no path leaves a
  // variable unassigned, which would infer a latch.
  always_comb begin
    state_d   = state_q;
    ok_d      = ok_q;
    id_d      = id_q;
    awready_o = 1'b0;
    wready_o  = 1'b0;
    bvalid_o  = 1'b0;
    bresp_o   = BRESP_OKAY;
    bid_o     = '0;
    push      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        awready_o = 1'b1;
        if (awvalid_i) begin
          ok_d    = (awaddr_i[31:0] == BASE_ADDR) && (awlen_i == 4'd0);
          id_d    = awid_i;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        // Rejected transactions are sunk even when the FIFO is full.
        wready_o = !ok_q || !full;
        if (wvalid_i && wready_o) begin
          if (ok_q) begin
            if (strb_legal(wstrb_i)) push = 1'b1;
            else                     ok_d = 1'b0;
          end
          if (wlast_i) state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        bvalid_o = 1'b1;
        bresp_o  = ok_q ? BRESP_OKAY : BRESP_SLVERR;
        bid_o    = id_q;
        if (bready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef CONSOLE_UART_TX_EN
  localparam int DIV_W = $clog2(CLK_DIV);

  logic             tx_busy_q;
  logic [9:0]       tx_shift_q;
  logic [3:0]       tx_bit_q;
  logic [DIV_W-1:0] tx_div_q;
  logic             unused_bits;

  assign pop         = !tx_busy_q && !empty;
  assign uart_sout_o = tx_busy_q ? tx_shift_q[0] : 1'b1;
  assign unused_bits = ^{awaddr_i[39:32], char_ready_i};

  // 8N1 serializer: load {stop, data, start} on pop, shift one bit per CLK_DIV.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      tx_busy_q  <= 1'b0;
      tx_shift_q <= '1;
      tx_bit_q   <= '0;
      tx_div_q   <= '0;
    end else if (pop) begin
      tx_busy_q  <= 1'b1;
      tx_shift_q <= {1'b1, fifo_data, 1'b0};
      tx_bit_q   <= '0;
      tx_div_q   <= '0;
    end else if (tx_busy_q) begin
      if (tx_div_q == DIV_W'(CLK_DIV - 1)) begin
        tx_div_q <= '0;
        if (tx_bit_q == 4'd9) begin
          tx_busy_q <= 1'b0;
        end else begin
          tx_bit_q   <= tx_bit_q + 1'b1;
          tx_shift_q <= {1'b1, tx_shift_q[9:1]};
        end
      end else begin
        tx_div_q <= tx_div_q + 1'b1;
      end
    end
  end
`else
  logic unused_bits;

  assign pop         = char_valid_o && char_ready_i;
  assign uart_sout_o = 1'b1;
  assign unused_bits = ^awaddr_i[39:32];
`endif

endmodule

// File: tb/tb_axi_console_wr_slave.sv
// Directed bench for axi_console_wr_slave. Inputs change on the falling edge,
// outputs are sampled on the falling edge. Build with CONSOLE_UART_TX_EN to
// exercise the serializer instead of the stream drain.
module tb_axi_console_wr_slave;

  logic         clk;
  logic         rst_b;
  logic         awvalid, awready;
  logic [39:0]  awaddr;
  logic [3:0]   awlen;
  logic [7:0]   awid;
  logic         wvalid, wready;
  logic [127:0] wdata;
  logic [15:0]  wstrb;
  logic         wlast;
  logic         bvalid, bready;
  logic [7:0]   bid;
  logic [1:0]   bresp;
  logic         char_valid, char_ready;
  logic [7:0]   char_data;
  logic         uart_sout;
  logic [4:0]   fifo_cnt;

  int errors = 0;
  int checks = 0;
  logic [7:0] rx_q [$];

  axi_console_wr_slave #(
    .BASE_ADDR  (32'h1001_5000),
    .ID_W       (8),
    .FIFO_DEPTH (16),
    .CLK_DIV    (4)
  ) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .awvalid_i    (awvalid),
    .awready_o    (awready),
    .awaddr_i     (awaddr),
    .awlen_i      (awlen),
    .awid_i       (awid),
    .wvalid_i     (wvalid),
    .wready_o     (wready),
    .wdata_i      (wdata),
    .wstrb_i      (wstrb),
    .wlast_i      (wlast),
    .bvalid_o     (bvalid),
    .bready_i     (bready),
    .bid_o        (bid),
    .bresp_o      (bresp),
    .char_valid_o (char_valid),
    .char_ready_i (char_ready),
    .char_data_o  (char_data),
    .uart_sout_o  (uart_sout),
    .fifo_cnt_o   (fifo_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every character leaving on the stream interface.
  always @(posedge clk) begin
    if (rst_b && char_valid && char_ready) rx_q.push_back(char_data);
  end

  function automatic logic [127:0] lane_data(input int lane, input logic [7:0] ch);
    logic [127:0] d;
    d = {16{8'hEE}};
    d[lane*32 +: 8] = ch;
    return d;
  endfunction

  function automatic logic [15:0] lane_strb(input int lane);
    logic [15:0] s;
    s = 16'h000f;
    return s << (lane * 4);
  endfunction

  // Full AXI write; returns at the falling edge after the last W beat with
  // the B channel sampled there. Caller owns the following edge.
  task automatic do_write(input logic [39:0] addr, input logic [3:0] len,
                          input logic [7:0] id, input logic [15:0] strb,
                          input logic [127:0] data, input int beats,
                          output logic bv, output logic [1:0] br,
                          output logic [7:0] bi);
    int t;
    awaddr = addr; awlen = len; awid = id; awvalid = 1'b1;
    t = 0;
    while (!awready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin
      checks++; errors++;
      $display("FAIL aw_timeout: awready low for %0d cycles, want 1", t);
    end
    @(negedge clk);
    awvalid = 1'b0;
    for (int b = 0; b < beats; b++) begin
      wvalid = 1'b1; wdata = data; wstrb = strb; wlast = (b == beats - 1);
      t = 0;
      while (!wready && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) begin
        checks++; errors++;
        $display("FAIL w_timeout: wready low for %0d cycles, want 1", t);
      end
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    bv = bvalid; br = bresp; bi = bid;
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    awvalid = 0; awaddr = '0; awlen = '0; awid = '0;
    wvalid = 0; wdata = '0; wstrb = '0; wlast = 0;
    bready = 1'b1; char_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (awready !== 1'b1)  begin errors++; $display("FAIL rst_awready: got %b want 1", awready); end
    checks++; if (wready !== 1'b0)   begin errors++; $display("FAIL rst_wready: got %b want 0", wready); end
    checks++; if (bvalid !== 1'b0)   begin errors++; $display("FAIL rst_bvalid: got %b want 0", bvalid); end
    checks++; if (bid !== 8'h00)     begin errors++; $display("FAIL rst_bid: got %h want 00", bid); end
    checks++; if (bresp !== 2'b00)   begin errors++; $display("FAIL rst_bresp: got %b want 00", bresp); end
    checks++; if (char_valid !== 1'b0) begin errors++; $display("FAIL rst_char_valid: got %b want 0", char_valid); end
    checks++; if (char_data !== 8'h00) begin errors++; $display("FAIL rst_char_data: got %h want 00", char_data); end
    checks++; if (uart_sout !== 1'b1)  begin errors++; $display("FAIL rst_uart_sout: got %b want 1", uart_sout); end
    checks++; if (fifo_cnt !== 5'd0)   begin errors++; $display("FAIL rst_fifo_cnt: got %0d want 0", fifo_cnt); end
    rst_b = 1'b1;
    @(negedge clk);
  endtask

  // Reset while in DATA: the FSM returns to IDLE and no B response appears.
  task automatic test_reset_mid();
    awaddr = 40'h00_1001_5000; awlen = 4'd0; awid = 8'h77; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    checks++; if (wready !== 1'b1) begin errors++; $display("FAIL aw_to_wready: got %b want 1", wready); end
    rst_b = 1'b0;
    #1;
    checks++; if (awready !== 1'b1 || wready !== 1'b0) begin errors++; $display("FAIL midrst_fsm: got awready=%b wready=%b want 1 0", awready, wready); end
    @(negedge clk);
    rst_b = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL midrst_bvalid: got %b want 0", bvalid); end
  endtask

  task automatic test_single();
    logic bv; logic [1:0] br; logic [7:0] bi;
    char_ready = 1'b0;
    do_write(40'h00_1001_5000, 4'd0, 8'h5A, 16'h00f0, lane_data(1, 8'h41), 1, bv, br, bi);
    checks++; if (bv !== 1'b1)    begin errors++; $display("FAIL single_bvalid: got %b want 1", bv); end
    checks++; if (br !== 2'b00)   begin errors++; $display("FAIL single_bresp: got %b want 00", br); end
    checks++; if (bi !== 8'h5A)   begin errors++; $display("FAIL single_bid: got %h want 5a", bi); end
    checks++; if (char_valid !== 1'b1) begin errors++; $display("FAIL single_char_valid: got %b want 1", char_valid); end
    checks++; if (char_data !== 8'h41) begin errors++; $display("FAIL single_char_data: got %h want 41", char_data); end
    checks++; if (fifo_cnt !== 5'd1)   begin errors++; $display("FAIL single_fifo_cnt: got %0d want 1", fifo_cnt); end
    @(negedge clk);
    checks++; if (bvalid !== 1'b0 || awready !== 1'b1) begin errors++; $display("FAIL single_b_done: got bvalid=%b awready=%b want 0 1", bvalid, awready); end
  endtask

  task automatic test_stream_order();
    logic bv; logic [1:0] br; logic [7:0] bi;
    logic [7:0] exp_ch [4];
    exp_ch[0] = 8'h61; exp_ch[1] = 8'h62; exp_ch[2] = 8'h63; exp_ch[3] = 8'h64;
    char_ready = 1'b1;
    repeat (2) @(negedge clk);
    rx_q.delete();
    for (int i = 0; i < 4; i++) begin
      do_write(40'h00_1001_5000, 4'd0, 8'(i + 16), lane_strb(i), lane_data(i, exp_ch[i]), 1, bv, br, bi);
      checks++; if (br !== 2'b00 || bi !== 8'(i + 16)) begin errors++; $display("FAIL stream_b%0d: got resp=%b id=%h want 00 %h", i, br, bi, 8'(i + 16)); end
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    checks++; if (rx_q.size() != 4) begin errors++; $display("FAIL stream_count: got %0d want 4", rx_q.size()); end
    for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp_ch[i]) begin errors++; $display("FAIL stream_char%0d: got %h want %h", i, rx_q[i], exp_ch[i]); end
    end
    char_ready = 1'b0;
  endtask

  task automatic test_errors();
    logic bv; logic [1:0] br; logic [7:0] bi;
    char_ready = 1'b0;
    repeat (2) @(negedge clk);
    do_write(40'h00_1001_5004, 4'd0, 8'h01, 16'h000f, lane_data(0, 8'h21), 1, bv, br, bi);
    checks++; if (bv !== 1'b1 || br !== 2'b10 || bi !== 8'h01) begin errors++; $display("FAIL badaddr_b: got v=%b resp=%b id=%h want 1 10 01", bv, br, bi); end
    checks++; if (fifo_cnt !== 5'd0) begin errors++; $display("FAIL badaddr_cnt: got %0d want 0", fifo_cnt); end
    @(negedge clk);
    do_write(40'h00_1001_5000, 4'd3, 8'h02, 16'h000f, lane_data(0, 8'h22), 4, bv, br, bi);
    checks++; if (bv !== 1'b1 || br !== 2'b10 || bi !== 8'h02) begin errors++; $display("FAIL burst_b: got v=%b resp=%b id=%h want 1 10 02", bv, br, bi); end
    checks++; if (fifo_cnt !== 5'd0) begin errors++; $display("FAIL burst_cnt: got %0d want 0", fifo_cnt); end
    @(negedge clk);
    do_write(40'h00_1001_5000, 4'd0, 8'h03, 16'h00ff, lane_data(0, 8'h23), 1, bv, br, bi);
    checks++; if (bv !== 1'b1 || br !== 2'b10) begin errors++; $display("FAIL badstrb_b: got v=%b resp=%b want 1 10", bv, br); end
    checks++; if (fifo_cnt !== 5'd0) begin errors++; $display("FAIL badstrb_cnt: got %0d want 0", fifo_cnt); end
    @(negedge clk);
    do_write(40'h00_1001_5000, 4'd0, 8'h04, 16'h0000, lane_data(0, 8'h24), 1, bv, br, bi);
    checks++; if (br !== 2'b10) begin errors++; $display("FAIL nostrb_bresp: got %b want 10", br); end
    checks++; if (fifo_cnt !== 5'd0) begin errors++; $display("FAIL nostrb_cnt: got %0d want 0", fifo_cnt); end
    @(negedge clk);
    // Only awaddr[31:0] is decoded; upper address bits are ignored.
    do_write(40'hAB_1001_5000, 4'd0, 8'h05, 16'h0f00, lane_data(2, 8'h58), 1, bv, br, bi);
    checks++; if (br !== 2'b00) begin errors++; $display("FAIL hiaddr_bresp: got %b want 00", br); end
    checks++; if (fifo_cnt !== 5'd1 || char_data !== 8'h58) begin errors++; $display("FAIL hiaddr_push: got cnt=%0d data=%h want 1 58", fifo_cnt, char_data); end
    @(negedge clk);
    char_ready = 1'b1;
    repeat (2) @(negedge clk);
    char_ready = 1'b0;
    checks++; if (fifo_cnt !== 5'd0) begin errors++; $display("FAIL hiaddr_drain: got %0d want 0", fifo_cnt); end
  endtask

  task automatic test_full();
    logic bv; logic [1:0] br; logic [7:0] bi;
    int t;
    int bad;
    char_ready = 1'b0;
    rx_q.delete();
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      do_write(40'h00_1001_5000, 4'd0, 8'(i), lane_strb(i % 4), lane_data(i % 4, 8'(8'h30 + i)), 1, bv, br, bi);
      if (br !== 2'b00) bad++;
      @(negedge clk);
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL fill_bresp: got %0d non-OKAY want 0", bad); end
    checks++; if (fifo_cnt !== 5'd16) begin errors++; $display("FAIL fill_cnt: got %0d want 16", fifo_cnt); end
    checks++; if (char_data !== 8'h30) begin errors++; $display("FAIL fill_head: got %h want 30", char_data); end
    // 17th write must stall on W until a character is popped.
    awaddr = 40'h00_1001_5000; awlen = 4'd0; awid = 8'h99; awvalid = 1'b1;
    t = 0;
    while (!awready && t < 50) begin @(negedge clk); t++; end
    @(negedge clk);
    awvalid = 1'b0;
    wvalid = 1'b1; wdata = lane_data(0, 8'h40); wstrb = 16'h000f; wlast = 1'b1;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      if (wready !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL full_stall: wready high %0d of 3 cycles, want 0", bad); end
    char_ready = 1'b1;
    @(negedge clk);
    char_ready = 1'b0;
    checks++; if (wready !== 1'b1 || fifo_cnt !== 5'd15) begin errors++; $display("FAIL full_release: got wready=%b cnt=%0d want 1 15", wready, fifo_cnt); end
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0;
    checks++; if (bvalid !== 1'b1 || bresp !== 2'b00 || bid !== 8'h99) begin errors++; $display("FAIL full_b: got v=%b resp=%b id=%h want 1 00 99", bvalid, bresp, bid); end
    checks++; if (fifo_cnt !== 5'd16) begin errors++; $display("FAIL full_peak: got %0d want 16", fifo_cnt); end
    @(negedge clk);
    char_ready = 1'b1;
    repeat (20) @(negedge clk);
    char_ready = 1'b0;
    checks++; if (rx_q.size() != 17 || fifo_cnt !== 5'd0) begin errors++; $display("FAIL drain_count: got %0d chars cnt=%0d want 17 0", rx_q.size(), fifo_cnt); end
    bad = 0;
    for (int i = 0; i < 17 && i < rx_q.size(); i++) begin
      if (rx_q[i] !== ((i == 16) ? 8'h40 : 8'(8'h30 + i))) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL drain_order: got %0d misordered chars want 0", bad); end
  endtask

  task automatic test_uart();
    logic bv; logic [1:0] br; logic [7:0] bi;
    logic [9:0] frame;
    int t;
    int bad;
    rst_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    frame = {1'b1, 8'h55, 1'b0};
    do_write(40'h00_1001_5000, 4'd0, 8'h33, 16'h000f, lane_data(0, 8'h55), 1, bv, br, bi);
    t = 0;
    while (uart_sout !== 1'b0 && t < 20) begin @(negedge clk); t++; end
    checks++; if (t >= 20) begin errors++; $display("FAIL uart_start: no start bit within %0d cycles", t); end
    for (int b = 0; b < 10; b++) begin
      bad = 0;
      for (int c = 0; c < 4; c++) begin
        if (uart_sout !== frame[b]) bad++;
        @(negedge clk);
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL uart_bit%0d: got wrong level %0d of 4 cycles want %b", b, bad, frame[b]); end
    end
    checks++; if (uart_sout !== 1'b1 || fifo_cnt !== 5'd0) begin errors++; $display("FAIL uart_idle: got sout=%b cnt=%0d want 1 0", uart_sout, fifo_cnt); end
    // Abort a frame of all-zero data bits with reset.
    do_write(40'h00_1001_5000, 4'd0, 8'h34, 16'h000f, lane_data(0, 8'h00), 1, bv, br, bi);
    t = 0;
    while (uart_sout !== 1'b0 && t < 20) begin @(negedge clk); t++; end
    repeat (10) @(negedge clk);
    checks++; if (uart_sout !== 1'b0) begin errors++; $display("FAIL uart_midframe: got %b want 0", uart_sout); end
    rst_b = 1'b0;
    #1;
    checks++; if (uart_sout !== 1'b1 || fifo_cnt !== 5'd0) begin errors++; $display("FAIL uart_abort: got sout=%b cnt=%0d want 1 0", uart_sout, fifo_cnt); end
    @(negedge clk);
    rst_b = 1'b1;
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (uart_sout !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL uart_post_reset: got low %0d of 8 cycles want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_single();
`ifndef CONSOLE_UART_TX_EN
    test_stream_order();
`endif
    test_errors();
`ifdef CONSOLE_UART_TX_EN
    test_uart();
`else
    test_full();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
